// File: rtl/cvmcu_boot_strap_sampler_if.sv
// Boot handshake and latched-strap bundle between the strap sampler (master) and SoC boot/reset logic (slave).
// The master drives every signal except boot_ack_i, which the boot controller returns.
interface cvmcu_boot_strap_sampler_if;
  logic boot_ack_i;
  logic bootsel_o;
  logic stm_o;
  logic straps_valid_o;
  logic soc_rstn_o;
  logic boot_req_o;
  logic strap_glitch_o;

  modport master (
    input  boot_ack_i,
    output bootsel_o, stm_o, straps_valid_o, soc_rstn_o, boot_req_o, strap_glitch_o
  );

  modport slave (
    output boot_ack_i,
    input  bootsel_o, stm_o, straps_valid_o, soc_rstn_o, boot_req_o, strap_glitch_o
  );
endinterface

// File: rtl/cvmcu_boot_strap_sampler.sv
// Synchronizes, filters and latches boot straps once, holds the SoC in reset, then handshakes a boot request.
// Latch after SYNC_STAGES+FILTER_CYCLES edges, release RST_HOLD_CYCLES later; boot_req_o holds until acked.
module cvmcu_boot_strap_sampler #(
  parameter int SYNC_STAGES     = 2,
  parameter int FILTER_CYCLES   = 8,
  parameter int RST_HOLD_CYCLES = 16
) (
  input  logic ref_clk_i,
  input  logic rstn_i,
  input  logic bootsel_i,
  input  logic stm_i,
  cvmcu_boot_strap_sampler_if.master boot_if
);

  localparam int SyncW = $clog2(SYNC_STAGES);
  localparam int FiltW = $clog2(FILTER_CYCLES + 1);
  localparam int HoldW = $clog2(RST_HOLD_CYCLES + 1);
  localparam logic [SyncW-1:0] SyncLast = SyncW'(SYNC_STAGES - 1);
  localparam logic [FiltW-1:0] FiltLast = FiltW'(FILTER_CYCLES - 1);
  localparam logic [HoldW-1:0] HoldLast = HoldW'(RST_HOLD_CYCLES - 1);
  localparam logic [HoldW-1:0] HoldMax  = HoldW'(RST_HOLD_CYCLES);

  typedef enum logic [2:0] {
    S_SYNC    = 3'd0,
    S_FILTER  = 3'd1,
    S_HOLD    = 3'd2,
    S_RELEASE = 3'd3,
    S_DONE    = 3'd4
  } state_e;

  state_e                 state_q, state_d;
  logic [SYNC_STAGES-1:0] bsel_sync_q, stm_sync_q;
  logic [1:0]             prev_q, prev_d;
  logic [SyncW-1:0]       sync_cnt_q, sync_cnt_d;
  logic [FiltW-1:0]       filt_cnt_q, filt_cnt_d;
  logic [HoldW-1:0]       hold_cnt_q, hold_cnt_d;
  logic                   bootsel_q, bootsel_d;
  logic                   stm_q, stm_d;
  logic                   valid_q, valid_d;
  logic                   soc_rstn_q, soc_rstn_d;
  logic                   boot_req_q, boot_req_d;
  logic                   glitch_q, glitch_d;

  logic [1:0] word, word_nxt;
  logic       word_match, latch_now, hold_done, ack_taken;

  assign word     = {bsel_sync_q[SYNC_STAGES-1], stm_sync_q[SYNC_STAGES-1]};
  assign word_nxt = {bsel_sync_q[SYNC_STAGES-2], stm_sync_q[SYNC_STAGES-2]};

  // While filling the synchronizer, prev tracks the value the output is about to take,
  // so the first filtered sample always counts as a match.
  assign prev_d     = (state_q == S_SYNC) ? word_nxt : word;
  assign word_match = (word == prev_q);
  assign latch_now  = (state_q == S_FILTER) && word_match && (filt_cnt_q == FiltLast);
  assign hold_done  = (state_q == S_HOLD) && (hold_cnt_q == HoldLast);
  assign ack_taken  = (state_q == S_RELEASE) && boot_if.boot_ack_i && boot_req_q;

  always_ff @(posedge ref_clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q     <= S_SYNC;
      bsel_sync_q <= '0;
      stm_sync_q  <= '0;
      prev_q      <= '0;
      sync_cnt_q  <= '0;
      filt_cnt_q  <= '0;
      hold_cnt_q  <= '0;
      bootsel_q   <= 1'b0;
      stm_q       <= 1'b0;
      valid_q     <= 1'b0;
      soc_rstn_q  <= 1'b0;
      boot_req_q  <= 1'b0;
      glitch_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      bsel_sync_q <= {bsel_sync_q[SYNC_STAGES-2:0], bootsel_i};
      stm_sync_q  <= {stm_sync_q[SYNC_STAGES-2:0], stm_i};
      prev_q      <= prev_d;
      sync_cnt_q  <= sync_cnt_d;
      filt_cnt_q  <= filt_cnt_d;
      hold_cnt_q  <= hold_cnt_d;
      bootsel_q   <= bootsel_d;
      stm_q       <= stm_d;
      valid_q     <= valid_d;
      soc_rstn_q  <= soc_rstn_d;
      boot_req_q  <= boot_req_d;
      glitch_q    <= glitch_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_SYNC:    if (sync_cnt_q == SyncLast) state_d = S_FILTER;
      S_FILTER:  if (latch_now)              state_d = S_HOLD;
      S_HOLD:    if (hold_done)              state_d = S_RELEASE;
      S_RELEASE: if (ack_taken)              state_d = S_DONE;
      S_DONE:                                state_d = S_DONE;
      default:                               state_d = S_SYNC;
    endcase
  end

  always_comb begin
    sync_cnt_d = sync_cnt_q;
    filt_cnt_d = filt_cnt_q;
    hold_cnt_d = hold_cnt_q;
    bootsel_d  = bootsel_q;
    stm_d      = stm_q;
    valid_d    = valid_q;
    soc_rstn_d = soc_rstn_q;
    boot_req_d = boot_req_q;
    glitch_d   = glitch_q;
    case (state_q)
      S_SYNC: sync_cnt_d = sync_cnt_q + 1'b1;
      S_FILTER: begin
        if (latch_now) begin
          bootsel_d = word[1];
          stm_d     = word[0];
          valid_d   = 1'b1;
        end else if (word_match) begin
          filt_cnt_d = filt_cnt_q + 1'b1;
        end else begin
          filt_cnt_d = '0;
        end
      end
      S_HOLD: begin
        if (hold_cnt_q != HoldMax) hold_cnt_d = hold_cnt_q + 1'b1;
        if (hold_done) begin
          soc_rstn_d = 1'b1;
          boot_req_d = 1'b1;
        end
      end
      S_RELEASE: if (ack_taken) boot_req_d = 1'b0;
      default: ;
    endcase
    // Post-latch strap activity is only reported; the latched values stay frozen.
    if ((state_q inside {S_HOLD, S_RELEASE, S_DONE}) && (word != {bootsel_q, stm_q}))
      glitch_d = 1'b1;
  end

  assign boot_if.bootsel_o      = bootsel_q;
  assign boot_if.stm_o          = stm_q;
  assign boot_if.straps_valid_o = valid_q;
  assign boot_if.soc_rstn_o     = soc_rstn_q;
  assign boot_if.boot_req_o     = boot_req_q;
  assign boot_if.strap_glitch_o = glitch_q;

endmodule

// File: tb/tb_cvmcu_boot_strap_sampler.sv
// Bench for the boot strap sampler: default and FILTER=1/HOLD=1 instances share pins and ack,
// checked every cycle against a window-based reference model plus literal timing points.
module tb_cvmcu_boot_strap_sampler;
  localparam int N = 2;

  logic clk = 1'b0;
  logic rstn = 1'b1;
  logic bootsel = 1'b0;
  logic stm = 1'b0;
  logic ack = 1'b0;

  cvmcu_boot_strap_sampler_if bi0 ();
  cvmcu_boot_strap_sampler_if bi1 ();
  assign bi0.boot_ack_i = ack;
  assign bi1.boot_ack_i = ack;

  cvmcu_boot_strap_sampler dut0 (
    .ref_clk_i(clk), .rstn_i(rstn), .bootsel_i(bootsel), .stm_i(stm), .boot_if(bi0)
  );
  cvmcu_boot_strap_sampler #(.SYNC_STAGES(2), .FILTER_CYCLES(1), .RST_HOLD_CYCLES(1)) dut1 (
    .ref_clk_i(clk), .rstn_i(rstn), .bootsel_i(bootsel), .stm_i(stm), .boot_if(bi1)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int e = 0;
  logic [1:0] hw [0:511];
  logic       ha [0:511];

  // Edge counter since reset release, plus pin/ack values sampled on each edge.
  always @(posedge clk or negedge rstn) begin
    if (!rstn) e <= 0;
    else if (e < 511) begin
      e         <= e + 1;
      hw[e + 1] <= {bootsel, stm};
      ha[e + 1] <= ack;
    end
  end

  // Returns {bootsel, stm, valid, soc_rstn, boot_req, glitch} after edge ec.
  // Latch edge k: synced word at edge k is the pin at edge k-N; it needs pins k-N-f..k-N equal,
  // where pin index 0 stands for the first sampled value.
  function automatic logic [5:0] model(input int f, input int h, input int ec);
    logic [5:0] r;
    int lat;
    logic [1:0] lw;
    bit ok;
    bit acked;
    r = '0;
    lat = -1;
    for (int k = N + f; k <= ec && lat < 0; k++) begin
      ok = 1'b1;
      for (int i = k - N - f; i < k - N; i++)
        if (hw[(i < 1) ? 1 : i] != hw[k - N]) ok = 1'b0;
      if (ok) lat = k;
    end
    if (lat < 0) return r;
    lw = hw[lat - N];
    r[5:4] = lw;
    r[3] = 1'b1;
    if (ec >= lat + h) begin
      r[2] = 1'b1;
      acked = 1'b0;
      for (int g = lat + h + 1; g <= ec; g++) if (ha[g]) acked = 1'b1;
      r[1] = !acked;
    end
    for (int g = lat + 1; g <= ec; g++) if (hw[g - N] != lw) r[0] = 1'b1;
    return r;
  endfunction

  task automatic chk6(input string name, input logic [5:0] act, input logic [5:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s edge=%0d got %b want %b", name, e, act, exp);
    end
  endtask

  task automatic lit(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s edge=%0d got %b want %b", name, e, act, exp);
    end
  endtask

  wire [5:0] o0 = {bi0.bootsel_o, bi0.stm_o, bi0.straps_valid_o, bi0.soc_rstn_o, bi0.boot_req_o, bi0.strap_glitch_o};
  wire [5:0] o1 = {bi1.bootsel_o, bi1.stm_o, bi1.straps_valid_o, bi1.soc_rstn_o, bi1.boot_req_o, bi1.strap_glitch_o};

  always @(negedge clk) begin
    chk6("model_dflt", o0, model(8, 16, e));
    chk6("model_f1h1", o1, model(1, 1, e));
  end

  task automatic go_to(input int n);
    int guard;
    guard = 0;
    while (e < n && guard < 1000) begin
      @(negedge clk);
      guard++;
    end
    if (e != n) begin
      checks++;
      errors++;
      $display("FAIL go_to edge=%0d want %0d", e, n);
    end
  endtask

  task automatic start(input logic b, input logic s, input logic a);
    @(negedge clk);
    #1 rstn = 1'b0;
    bootsel = b;
    stm = s;
    ack = a;
    repeat (2) @(negedge clk);
    lit("rst_vld", bi0.straps_valid_o, 1'b0);
    lit("rst_soc", bi0.soc_rstn_o, 1'b0);
    lit("rst_req", bi1.boot_req_o, 1'b0);
    #1 rstn = 1'b1;
  endtask

  initial begin
    #1 rstn = 1'b0;

    // Basic boot with stable straps, both parameter sets.
    start(1'b1, 1'b0, 1'b0);
    go_to(2);  lit("p_vld_e2", bi1.straps_valid_o, 1'b0);
    go_to(3);  lit("p_vld_e3", bi1.straps_valid_o, 1'b1);
               lit("p_soc_e3", bi1.soc_rstn_o, 1'b0);
    go_to(4);  lit("p_soc_e4", bi1.soc_rstn_o, 1'b1);
               lit("p_req_e4", bi1.boot_req_o, 1'b1);
    go_to(9);  lit("vld_e9", bi0.straps_valid_o, 1'b0);
    go_to(10); lit("vld_e10", bi0.straps_valid_o, 1'b1);
               lit("bsel_e10", bi0.bootsel_o, 1'b1);
               lit("stm_e10", bi0.stm_o, 1'b0);
    go_to(25); lit("soc_e25", bi0.soc_rstn_o, 1'b0);
    go_to(26); lit("soc_e26", bi0.soc_rstn_o, 1'b1);
               lit("req_e26", bi0.boot_req_o, 1'b1);
    go_to(29); lit("req_e29", bi0.boot_req_o, 1'b1);
    ack = 1'b1;
    go_to(30); lit("req_e30", bi0.boot_req_o, 1'b0);
    ack = 1'b0;
    go_to(34);

    // Filter restart: bootsel rises after edge 5.
    start(1'b0, 1'b0, 1'b0);
    go_to(5);
    bootsel = 1'b1;
    go_to(15); lit("fr_vld_e15", bi0.straps_valid_o, 1'b0);
    go_to(16); lit("fr_vld_e16", bi0.straps_valid_o, 1'b1);
               lit("fr_bsel", bi0.bootsel_o, 1'b1);
    go_to(40);

    // Post-latch glitch on stm after edge 15.
    start(1'b0, 1'b0, 1'b0);
    go_to(15);
    stm = 1'b1;
    go_to(17); lit("gl_e17", bi0.strap_glitch_o, 1'b0);
    go_to(18); lit("gl_e18", bi0.strap_glitch_o, 1'b1);
               lit("gl_stm", bi0.stm_o, 1'b0);
    go_to(30);
    ack = 1'b1;
    go_to(34); lit("gl_done", bi0.strap_glitch_o, 1'b1);
               lit("gl_req", bi0.boot_req_o, 1'b0);
               lit("gl_stm_done", bi0.stm_o, 1'b0);

    // Early ack held from the start.
    start(1'b0, 1'b1, 1'b1);
    go_to(25); lit("ea_req_e25", bi0.boot_req_o, 1'b0);
    go_to(26); lit("ea_req_e26", bi0.boot_req_o, 1'b1);
    go_to(27); lit("ea_req_e27", bi0.boot_req_o, 1'b0);
    go_to(32); lit("ea_req_e32", bi0.boot_req_o, 1'b0);
               lit("ea_soc_e32", bi0.soc_rstn_o, 1'b1);

    // Reset during HOLD, then a full repeat.
    start(1'b1, 1'b1, 1'b0);
    go_to(19);
    @(posedge clk);
    #2 rstn = 1'b0;
    #1;
    lit("mr_vld", bi0.straps_valid_o, 1'b0);
    lit("mr_bsel", bi0.bootsel_o, 1'b0);
    lit("mr_stm", bi0.stm_o, 1'b0);
    lit("mr_p_soc", bi1.soc_rstn_o, 1'b0);
    lit("mr_p_req", bi1.boot_req_o, 1'b0);
    repeat (2) @(negedge clk);
    #1 rstn = 1'b1;
    go_to(9);  lit("mr_vld_e9", bi0.straps_valid_o, 1'b0);
    go_to(10); lit("mr_vld_e10", bi0.straps_valid_o, 1'b1);
    go_to(25); lit("mr_soc_e25", bi0.soc_rstn_o, 1'b0);
    go_to(26); lit("mr_soc_e26", bi0.soc_rstn_o, 1'b1);
    go_to(30);

    // Randomized runs: noisy straps early, stable window, sparse post-latch glitches, random ack.
    for (int r = 0; r < 8; r++) begin
      start(1'($urandom), 1'($urandom), 1'b0);
      for (int c = 1; c <= 100; c++) begin
        if (c < 25) begin
          if ($urandom_range(0, 2) == 0) {bootsel, stm} = 2'($urandom);
        end else if (c > 45 && $urandom_range(0, 19) == 0) begin
          {bootsel, stm} = 2'($urandom);
        end
        ack = ($urandom_range(0, 3) == 0);
        go_to(c);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
